// File: rtl/alu_op_issue_if.sv
// Command/result bundle between a command source, alu_op_issue and alu_simple.
// master: the side that supplies commands and the ALU result (bench / upstream).
// slave:  alu_op_issue itself.
interface alu_op_issue_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_sel;
    logic         issue_en;
    logic         flush;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_sel;
    logic [W-1:0] alu_y;
    logic         res_valid;
    logic [W-1:0] res_y;
    logic [1:0]   res_sel;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_sel, issue_en, flush, alu_y,
        input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_y, res_sel, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, issue_en, flush, alu_y,
        output in_ready, alu_a, alu_b, alu_sel, res_valid, res_y, res_sel, busy
    );
endinterface

// File: rtl/alu_op_issue.sv
// alu_op_issue: command FIFO and issue stage in front of alu_simple.
// Buffers ops, issues at most one per cycle, delays alu_sel one cycle to meet
// the ALU's operand registers, and tracks in-flight ops to tag returning results.
// Optional: define ALU_ISSUE_CNT_EN to add the 16-bit issue_cnt output.
module alu_op_issue #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ALU_ISSUE_CNT_EN
    output logic [15:0] issue_cnt,
`endif
    alu_op_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   mem_a   [DEPTH];
    logic [W-1:0]   mem_b   [DEPTH];
    logic [1:0]     mem_sel [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic           fifo_empty, fifo_full, push, pop, rdy_en;
    logic [W-1:0]   alu_a_q, alu_b_q, res_y_q;
    logic [1:0]     issue_sel, alu_sel_q;
    logic           issue_v;
    logic [2:0]     trk_v;
    logic [2:0][1:0] trk_sel;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // rdy_en keeps in_ready low through reset and for the first cycle after release
    assign bus.in_ready = rdy_en & !fifo_full & !bus.flush & (state != DRAIN);
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = !fifo_empty & bus.issue_en & !bus.flush & (state != DRAIN);

    assign wr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = trk_v[2];
    assign bus.res_sel   = trk_sel[2];
    assign bus.res_y     = res_y_q;
    assign bus.busy      = !fifo_empty | issue_v | (|trk_v);

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]]   <= bus.in_a;
            mem_b[wr_ptr[AW-1:0]]   <= bus.in_b;
            mem_sel[wr_ptr[AW-1:0]] <= bus.in_sel;
        end
    end

    // FIFO pointers; flush empties the queue by catching the read pointer up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            wr_ptr <= wr_nxt;
            rd_ptr <= bus.flush ? wr_ptr : rd_nxt;
        end
    end

    // Issue stage: operands registered at the pop, sel follows one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            issue_sel <= '0;
            issue_v   <= 1'b0;
            alu_sel_q <= '0;
        end else begin
            alu_a_q   <= pop ? mem_a[rd_ptr[AW-1:0]]   : '0;
            alu_b_q   <= pop ? mem_b[rd_ptr[AW-1:0]]   : '0;
            issue_sel <= pop ? mem_sel[rd_ptr[AW-1:0]] : '0;
            issue_v   <= pop;
            alu_sel_q <= issue_sel;
        end
    end

    // In-flight tracker; res_y only captures when a tracked result is on alu_y,
    // so stale ALU contents after reset never leak out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_v   <= '0;
            trk_sel <= '0;
            res_y_q <= '0;
        end else begin
            trk_v   <= {trk_v[1:0], issue_v};
            trk_sel <= {trk_sel[1:0], issue_sel};
            if (trk_v[1]) res_y_q <= bus.alu_y;
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    // Count of ops popped toward the ALU; wraps naturally, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      issue_cnt <= '0;
        else if (pop) issue_cnt <= issue_cnt + 16'd1;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state reflects occupancy of the coming cycle, so DRAIN hands over to
    // IDLE in the same cycle busy first drops
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = DRAIN;
        end else if (state == DRAIN) begin
            if (!(issue_v | trk_v[0] | trk_v[1])) state_nxt = IDLE;
        end else if ((wr_nxt != rd_nxt) | pop | issue_v | trk_v[0] | trk_v[1]) begin
            state_nxt = RUN;
        end else begin
            state_nxt = IDLE;
        end
    end
endmodule
